ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
Sequencer that sits directly upstream of the single-port RAM (s_ram) and drives its en/addr/data_in inputs. On a start command it writes a deterministic pattern to a contiguous address window, then reads the window back. It compares each word returned on data_out against the expected value and reports pass/fail, an error count and the first failing address. The block serves as the self-checking traffic source for RAM bring-up and regression.

Parameters:
ADDR_W, 4, RAM address width; RAM depth is 2^ADDR_W.
DATA_W, 8, RAM data width.
RD_LAT, 1, cycles from a read address on ram_addr to valid ram_data_out; legal range 1..4.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  command strobe, sampled only in IDLE.
base_addr  input  ADDR_W  first address of the window.
len_m1  input  ADDR_W  window length minus 1; N = len_m1+1 words.
seed  input  DATA_W  pattern seed.
busy  output  1  high from start acceptance until done.
done  output  1  one-cycle completion pulse.
pass  output  1  1 if the last run had zero mismatches.
err_count  output  ADDR_W+1  mismatch count; saturates at all-ones.
first_err_addr  output  ADDR_W  RAM address of the first mismatch; 0 if none.
ram_en  output  1  1 = write, 0 = read (s_ram en).
ram_addr  output  ADDR_W  to s_ram addr.
ram_data_in  output  DATA_W  to s_ram data_in.
ram_data_out  input  DATA_W  from s_ram data_out.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, FSM to IDLE, compare pipeline cleared.
- Reset mid-run aborts the run with no done pulse.
- All outputs are registered.
- FSM states and transitions:
  - IDLE -> WRITE on start.
  - WRITE -> READ after N cycles.
  - READ -> DRAIN after N cycles.
  - DRAIN -> DONE after RD_LAT cycles.
  - DONE -> IDLE after 1 cycle.
- Start acceptance (edge t0, state IDLE, start=1):
  - Latch base_addr, len_m1 and seed.
  - Clear err_count, pass and first_err_addr.
  - busy <= 1; offset <= 0.
- start is ignored when not in IDLE, including in the DONE cycle.
- WRITE:
  - For offset k = 0..N-1, present ram_en=1, ram_addr=(base+k) mod 2^ADDR_W, ram_data_in=(seed+k) mod 2^DATA_W.
  - Word k is presented in the cycle after edge t0+k.
- READ:
  - For k = 0..N-1, present ram_en=0, ram_addr=(base+k) mod 2^ADDR_W in the cycle after edge t0+N+k.
  - ram_data_in holds its last value.
  - Each read pushes {valid, expected=(seed+k), addr} into an RD_LAT-deep delay line.
- Compare:
  - ram_data_out is sampled at the edge RD_LAT cycles after its address was presented.
  - On mismatch: err_count += 1 (saturating).
  - On the first mismatch of the run, first_err_addr <= addr.
  - Compares continue through DRAIN.
- DONE:
  - done=1 and busy=0 from edge t0+2N+RD_LAT for exactly one cycle.
  - pass = (err_count==0).
  - err_count, pass and first_err_addr then hold until the next accepted start.
- IDLE: ram_en=0; ram_addr and ram_data_in hold their last values.
- Wrap-around: address and pattern arithmetic are modulo 2^ADDR_W and 2^DATA_W.
- len_m1 = 2^ADDR_W-1 covers the full RAM with no address aliasing.
- N=1 is legal: one write, one read, done at t0+2+RD_LAT.
- If inputs change while busy, the latched copies are used.

Test Plan:
- Basic run (RD_LAT=1, correct RAM model), base=0, len_m1=3, seed=8'h10 -> writes addr 0..3 with 10,11,12,13; reads 0..3; done at t0+9; pass=1, err_count=0, first_err_addr=0.
- Address wrap, base=14, len_m1=3 -> ram_addr sequence 14,15,0,1 for both write and read; data 8'h10..8'h13; pass=1.
- Fault injection: RAM model forces bit0=1 at addr 2, seed=8'h10, base=0, len_m1=3 -> err_count=1, first_err_addr=2, pass=0.
- Full RAM, base=0, len_m1=15, seed=8'hFF -> data FF,00,01..0E; done at t0+33; pass=1.
- Start pulsed at t0+3 and t0+6 during busy -> ignored; exactly one done pulse; a new start after done is accepted and clears the previous results.
- rst asserted at t0+2 during WRITE -> same cycle: busy=0, ram_en=0, ram_addr=0, err_count=0; no done; a subsequent start with N=1 completes at t0'+3 with pass=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// RAM BIST sequencer: writes a seed-based incrementing pattern over an address window,
// reads it back through an RD_LAT-deep compare pipeline and reports pass/errors.
module ram_bist_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   len_m1,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data_in,
  input  logic [DATA_W-1:0]   ram_data_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DRN_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
  logic                ram_en_q, ram_en_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;

  // Compare delay line: stage 0 captures the read that was on the RAM bus last cycle.
  logic                pipe_vld_q  [RD_LAT];
  logic                pipe_vld_d  [RD_LAT];
  logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];
  logic [DATA_W-1:0]   pipe_exp_d  [RD_LAT];
  logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_addr_d [RD_LAT];

  logic [ADDR_W-1:0]   off_nx;
  logic                mismatch;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign ram_en         = ram_en_q;
  assign ram_addr       = ram_addr_q;
  assign ram_data_in    = ram_data_in_q;

  always_comb begin
    state_d          = state_q;
    off_d            = off_q;
    base_d           = base_q;
    len_d            = len_q;
    seed_d           = seed_q;
    drn_d            = drn_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    ram_en_d         = 1'b0;
    ram_addr_d       = ram_addr_q;
    ram_data_in_d    = ram_data_in_q;
    rd_vld_d         = 1'b0;
    rd_exp_d         = rd_exp_q;

    off_nx = off_q + ADDR_W'(1);

    pipe_vld_d[0]  = rd_vld_q;
    pipe_exp_d[0]  = rd_exp_q;
    pipe_addr_d[0] = ram_addr_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    mismatch = pipe_vld_q[RD_LAT-1] && (ram_data_out != pipe_exp_q[RD_LAT-1]);
    if (mismatch) begin
      if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
      if (err_count_q == '0) first_err_addr_d = pipe_addr_q[RD_LAT-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_WRITE;
          base_d           = base_addr;
          len_d            = len_m1;
          seed_d           = seed;
          off_d            = '0;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          ram_en_d         = 1'b1;
          ram_addr_d       = base_addr;
          ram_data_in_d    = seed;
        end
      end
      S_WRITE: begin
        if (off_q == len_q) begin
          state_d    = S_READ;
          off_d      = '0;
          ram_addr_d = base_q;
          rd_vld_d   = 1'b1;
          rd_exp_d   = seed_q;
        end else begin
          off_d         = off_nx;
          ram_en_d      = 1'b1;
          ram_addr_d    = base_q + off_nx;
          ram_data_in_d = seed_q + DATA_W'(off_nx);
        end
      end
      S_READ: begin
        if (off_q == len_q) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          off_d      = off_nx;
          ram_addr_d = base_q + off_nx;
          rd_vld_d   = 1'b1;
          rd_exp_d   = seed_q + DATA_W'(off_nx);
        end
      end
      S_DRAIN: begin
        // The last read's compare lands on the same edge as the DONE entry.
        if (drn_q == DRN_W'(RD_LAT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_count_d == '0);
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      off_q            <= '0;
      base_q           <= '0;
      len_q            <= '0;
      seed_q           <= '0;
      drn_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      ram_en_q         <= 1'b0;
      ram_addr_q       <= '0;
      ram_data_in_q    <= '0;
      rd_vld_q         <= 1'b0;
      rd_exp_q         <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= '0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      off_q            <= off_d;
      base_q           <= base_d;
      len_q            <= len_d;
      seed_q           <= seed_d;
      drn_q            <= drn_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      ram_en_q         <= ram_en_d;
      ram_addr_q       <= ram_addr_d;
      ram_data_in_q    <= ram_data_in_d;
      rd_vld_q         <= rd_vld_d;
      rd_exp_q         <= rd_exp_d;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_exp_q[i]  <= pipe_exp_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 1-cycle registered-read RAM model and fault injection.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [3:0] len_m1 = '0;
  logic [7:0] seed = '0;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_err_addr;
  logic       ram_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = '0;

  int n_cmp = 0;
  int n_fail = 0;

  ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len_m1(len_m1),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM model, one cycle read latency, optional stuck bit0 at fault_addr.
  logic [7:0] mem [16];
  logic       fault_en = 1'b0;
  logic [3:0] fault_addr = '0;
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr] | {7'd0, (fault_en && ram_addr == fault_addr)};
  end

  logic       obs_en   [64];
  logic [3:0] obs_addr [64];
  logic [7:0] obs_din  [64];
  int         done_cyc, extra_done;
  logic       busy0, pass0, d_busy, d_pass, post_busy;
  logic [4:0] err0, d_err;
  logic [3:0] first0, d_first;

  task automatic do_run(input logic [3:0] b, input logic [3:0] l, input logic [7:0] s,
                        input bit inject);
    @(negedge clk);
    base_addr = b; len_m1 = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs_en[0] = ram_en; obs_addr[0] = ram_addr; obs_din[0] = ram_data_in;
    busy0 = busy; pass0 = pass; err0 = err_count; first0 = first_err_addr;
    done_cyc = -1;
    for (int c = 1; c < 64; c++) begin
      if (inject && (c == 3 || c == 6)) begin
        start = 1'b1; base_addr = 4'd9; len_m1 = 4'd1; seed = 8'hAA;
      end
      @(posedge clk); #1;
      start = 1'b0;
      obs_en[c] = ram_en; obs_addr[c] = ram_addr; obs_din[c] = ram_data_in;
      if (done) begin
        done_cyc = c; d_busy = busy; d_pass = pass; d_err = err_count; d_first = first_err_addr;
        break;
      end
    end
    extra_done = 0; post_busy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy) post_busy = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done, pass, err_count, first_err_addr, ram_en, ram_addr, ram_data_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d first=%0d en=%b addr=%0d din=%h, need all 0",
               busy, done, pass, err_count, first_err_addr, ram_en, ram_addr, ram_data_in);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    do_run(4'd0, 4'd3, 8'h10, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic       e_en;
      logic [3:0] e_addr;
      logic [7:0] e_din;
      e_en = (k < 4); e_addr = 4'(k % 4); e_din = (k < 4) ? 8'(8'h10 + k) : 8'h13;
      n_cmp++;
      if (obs_en[k] !== e_en || obs_addr[k] !== e_addr || obs_din[k] !== e_din) begin
        n_fail++;
        $display("FAIL basic_seq[%0d]: got en=%b addr=%0d din=%h, need en=%b addr=%0d din=%h",
                 k, obs_en[k], obs_addr[k], obs_din[k], e_en, e_addr, e_din);
      end
    end
    n_cmp++;
    if (done_cyc !== 9 || d_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got cycle=%0d busy=%b, need cycle=9 busy=0", done_cyc, d_busy);
    end
    n_cmp++;
    if (d_pass !== 1'b1 || d_err !== 5'd0 || d_first !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_result: got pass=%b err=%0d first=%0d, need 1/0/0", d_pass, d_err, d_first);
    end
    n_cmp++;
    if (extra_done !== 0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hold: got extra_done=%0d pass=%b, need 0 and 1", extra_done, pass);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [4];
    seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;
    do_run(4'd14, 4'd3, 8'h10, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (obs_addr[k] !== seq[k % 4] || obs_en[k] !== (k < 4) ||
          (k < 4 && obs_din[k] !== 8'(8'h10 + k))) begin
        n_fail++;
        $display("FAIL wrap_seq[%0d]: got en=%b addr=%0d din=%h, need addr=%0d",
                 k, obs_en[k], obs_addr[k], obs_din[k], seq[k % 4]);
      end
    end
    n_cmp++;
    if (done_cyc !== 9 || d_pass !== 1'b1 || d_err !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_result: got cycle=%0d pass=%b err=%0d, need 9/1/0", done_cyc, d_pass, d_err);
    end
  endtask

  task automatic test_fault();
    fault_en = 1'b1; fault_addr = 4'd2;
    do_run(4'd0, 4'd3, 8'h10, 1'b0);
    fault_en = 1'b0;
    n_cmp++;
    if (done_cyc !== 9 || d_pass !== 1'b0 || d_err !== 5'd1 || d_first !== 4'd2) begin
      n_fail++;
      $display("FAIL fault_result: got cycle=%0d pass=%b err=%0d first=%0d, need 9/0/1/2",
               done_cyc, d_pass, d_err, d_first);
    end
    n_cmp++;
    if (pass !== 1'b0 || err_count !== 5'd1 || first_err_addr !== 4'd2) begin
      n_fail++;
      $display("FAIL fault_hold: got pass=%b err=%0d first=%0d, need 0/1/2", pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_busy_start();
    do_run(4'd3, 4'd3, 8'h40, 1'b1);
    n_cmp++;
    if (busy0 !== 1'b1 || pass0 !== 1'b0 || err0 !== 5'd0 || first0 !== 4'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got busy=%b pass=%b err=%0d first=%0d, need 1/0/0/0",
               busy0, pass0, err0, first0);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (obs_addr[k] !== 4'(3 + k % 4) || obs_en[k] !== (k < 4) ||
          (k < 4 && obs_din[k] !== 8'(8'h40 + k))) begin
        n_fail++;
        $display("FAIL ignore_seq[%0d]: got en=%b addr=%0d din=%h, need addr=%0d",
                 k, obs_en[k], obs_addr[k], obs_din[k], 3 + k % 4);
      end
    end
    n_cmp++;
    if (done_cyc !== 9 || d_pass !== 1'b1 || d_err !== 5'd0 || d_first !== 4'd0 ||
        extra_done !== 0 || post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got cycle=%0d pass=%b err=%0d first=%0d extra=%0d pbusy=%b, need 9/1/0/0/0/0",
               done_cyc, d_pass, d_err, d_first, extra_done, post_busy);
    end
  endtask

  task automatic test_full();
    do_run(4'd0, 4'd15, 8'hFF, 1'b0);
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (obs_addr[k] !== 4'(k % 16) || obs_en[k] !== (k < 16) ||
          (k < 16 && obs_din[k] !== 8'(8'hFF + k))) begin
        n_fail++;
        $display("FAIL full_seq[%0d]: got en=%b addr=%0d din=%h, need addr=%0d",
                 k, obs_en[k], obs_addr[k], obs_din[k], k % 16);
      end
    end
    n_cmp++;
    if (done_cyc !== 33 || d_pass !== 1'b1 || d_err !== 5'd0) begin
      n_fail++;
      $display("FAIL full_result: got cycle=%0d pass=%b err=%0d, need 33/1/0", done_cyc, d_pass, d_err);
    end
  endtask

  task automatic test_midrun_reset();
    int seen;
    @(negedge clk);
    base_addr = 4'd0; len_m1 = 4'd3; seed = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || ram_en !== 1'b0 || ram_addr !== 4'd0 || err_count !== 5'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b en=%b addr=%0d err=%0d done=%b, need all 0",
               busy, ram_en, ram_addr, err_count, done);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, need 0", seen);
    end
    do_run(4'd5, 4'd0, 8'h77, 1'b0);
    n_cmp++;
    if (obs_en[0] !== 1'b1 || obs_addr[0] !== 4'd5 || obs_din[0] !== 8'h77 ||
        obs_en[1] !== 1'b0 || obs_addr[1] !== 4'd5) begin
      n_fail++;
      $display("FAIL n1_seq: got en=%b/%b addr=%0d/%0d din=%h, need 1/0 5/5 77",
               obs_en[0], obs_en[1], obs_addr[0], obs_addr[1], obs_din[0]);
    end
    n_cmp++;
    if (done_cyc !== 3 || d_pass !== 1'b1 || d_err !== 5'd0) begin
      n_fail++;
      $display("FAIL n1_result: got cycle=%0d pass=%b err=%0d, need 3/1/0", done_cyc, d_pass, d_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_busy_start();
    test_full();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
